fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0800: instruction word driven into IF/ID on reset and on flush.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold from decode/hazard logic; IF/ID and PC shall hold.
REQ-006 redirect  input  1  taken branch/jump resolved downstream; flush and retarget.
REQ-007 redirectPC  input  16  target PC, valid when redirect=1.
REQ-008 haltD  input  1  HALT currently decoded from IF/ID.
REQ-009 imemAddr  output  16  instruction memory address, combinationally equal to PC.
REQ-010 imemEn  output  1  instruction memory read request.
REQ-011 imemData  input  16  instruction word, valid when imemDone=1.
REQ-012 imemDone  input  1  imemData is valid for the imemAddr presented this cycle.
REQ-013 instruction  output  16  registered IF/ID instruction, consumed by decode.
REQ-014 pcPlus2  output  16  registered PC+2 of the instruction in IF/ID.
REQ-015 instValid  output  1  IF/ID holds a real fetched instruction (0 = bubble).
REQ-016 err  output  1  sticky misaligned-target error.

Function
REQ-017 States SHALL be RUN, HOLD and HALTED; imemEn=1 only in RUN with rst=0.
REQ-018 RUN, imemDone=1, stall=0: IF/ID<={imemData, PC+2, valid=1} and PC<=PC+2; remain in RUN.
REQ-019 RUN, imemDone=1, stall=1: imemData SHALL be captured in a hold buffer, IF/ID and PC held; go to HOLD.
REQ-020 RUN, imemDone=0: if stall=0, IF/ID<={NOP_INSTR, held pcPlus2, valid=0}; if stall=1, IF/ID held; PC held in both cases.
REQ-021 HOLD: imemEn=0; when stall=0, IF/ID<={buffer, PC+2, valid=1}, PC<=PC+2, go to RUN.
REQ-022 redirect=1 in RUN or HOLD SHALL override stall, haltD and imemDone: PC<=redirectPC, IF/ID<={NOP_INSTR, pcPlus2 held, valid=0}, buffer discarded, next state RUN.
REQ-023 haltD=1 with redirect=0 and stall=0 SHALL enter HALTED; IF/ID is held.
REQ-024 HALTED: imemEn=0, PC and IF/ID frozen, redirect and stall ignored; exit only via rst.
REQ-025 PC arithmetic is modulo 2^16: 16'hFFFE+2 = 16'h0000, with no error.
REQ-026 redirect=1 with redirectPC[0]=1 SHALL set err on the next edge, sticky until rst; PC is still loaded with redirectPC unmodified.
REQ-027 Fetch-to-IF/ID latency SHALL be one edge after the imemDone cycle; a zero-wait memory sustains one instruction per cycle.

Reset
REQ-028 On a clock edge with rst=1: PC=RESET_PC, state=RUN, instruction=NOP_INSTR, pcPlus2=16'h0000, instValid=0, err=0, buffer cleared.
REQ-029 During the rst=1 cycle, imemEn=0; reset overrides every other input, including when it arrives mid-HOLD or in HALTED.

Structure
REQ-030 The shared package SHALL hold the state encoding (RUN=2'b00, HOLD=2'b01, HALTED=2'b10) and the NOP_INSTR constant for use by decode and the flush logic.
REQ-031 One sub-module, ifid_reg, SHALL implement the instruction/pcPlus2/instValid pipeline register with load, hold and flush controls.

Verification
REQ-032 Reset, then zero-wait memory returning 16'hA000 at 0x0000 and 16'hA100 at 0x0002: after 2 edges instruction=16'hA100, pcPlus2=0x0004, instValid=1.
REQ-033 Memory with 2 wait cycles: instValid=0 with instruction=16'h0800 during the waits; the word appears one edge after imemDone; PC advances only then.
REQ-034 imemDone=1 with stall=1 for 3 cycles: state=HOLD, imemEn=0, IF/ID unchanged; the edge after stall drops loads the buffered word and PC advances by 2.
REQ-035 redirect=1, redirectPC=0x0040, applied simultaneously with stall=1 and imemDone=1: next cycle PC=0x0040, instruction=16'h0800, instValid=0, state=RUN.
REQ-036 haltD=1 at PC=0x0010: state=HALTED, imemEn=0, PC stays 0x0010 for 10 cycles even with redirect=1; rst returns PC to 0x0000.
REQ-037 redirectPC=0x0033: err=1 on the next edge and stays 1 across later fetches until rst; redirect to 0xFFFE then one fetch gives PC=0x0000, pcPlus2=0x0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the flush/bubble
// instruction word and small PC helpers used by fetch and decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HOLD   = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR_C = 16'h0800;
  localparam logic [15:0] PC_STEP_C   = 16'h0002;

  // Wraps modulo 2^16 by construction of the 16-bit result.
  function automatic logic [15:0] pc_add2(input logic [15:0] pc);
    return pc + PC_STEP_C;
  endfunction

  function automatic logic is_misaligned(input logic [15:0] pc);
    return pc[0];
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: instruction word, PC+2 and valid flag with
// load, hold and flush (bubble) controls.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_plus2_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc_plus2_o,
  output logic        valid_o
);

  logic [15:0] instr_q;
  logic [15:0] pc_plus2_q;
  logic        valid_q;

  // Flush keeps pcPlus2 so decode still sees the last real sequential PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= pc_plus2_q;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus2_q <= pc_plus2_i;
      valid_q    <= 1'b1;
    end else begin
      instr_q    <= instr_q;
      pc_plus2_q <= pc_plus2_q;
      valid_q    <= valid_q;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus2_o = pc_plus2_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, memory request, stall hold buffer, redirect
// flush, halt and sticky misaligned-target error, feeding the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  input  logic        haltD,
  output logic [15:0] imemAddr,
  output logic        imemEn,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  output logic [15:0] instruction,
  output logic [15:0] pcPlus2,
  output logic        instValid,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  buf_q, buf_d;
  logic         err_q, err_d;

  logic         ifid_load_s;
  logic         ifid_flush_s;
  logic [15:0]  ifid_instr_s;
  logic [15:0]  pc_plus2_s;

  assign pc_plus2_s = pc_add2(pc_q);

  // Next-state decode; redirect has priority over halt, stall and memory.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    err_d        = err_q;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_instr_s = imemData;
    case (state_q)
      ST_RUN, ST_HOLD: begin
        if (redirect) begin
          pc_d         = redirectPC;
          buf_d        = 16'h0000;
          err_d        = err_q | is_misaligned(redirectPC);
          ifid_flush_s = 1'b1;
          state_d      = ST_RUN;
        end else if (haltD && !stall) begin
          buf_d   = 16'h0000;
          state_d = ST_HALTED;
        end else if (state_q == ST_HOLD) begin
          if (!stall) begin
            ifid_load_s  = 1'b1;
            ifid_instr_s = buf_q;
            pc_d         = pc_plus2_s;
            state_d      = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (imemDone && !stall) begin
          ifid_load_s = 1'b1;
          pc_d        = pc_plus2_s;
          state_d     = ST_RUN;
        end else if (imemDone) begin
          // The word arrived while decode is blocked: park it, stop fetching.
          buf_d   = imemData;
          state_d = ST_HOLD;
        end else if (!stall) begin
          ifid_flush_s = 1'b1;
          state_d      = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, PC, hold buffer and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      buf_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ifid_load_s),
    .flush_i    (ifid_flush_s),
    .instr_i    (ifid_instr_s),
    .pc_plus2_i (pc_plus2_s),
    .instr_o    (instruction),
    .pc_plus2_o (pcPlus2),
    .valid_o    (instValid)
  );

  // The request is gated by rst so memory sees no read during reset.
  assign imemEn   = (state_q == ST_RUN) & ~rst;
  assign imemAddr = pc_q;
  assign err      = err_q;

endmodule
